// File: rtl/shift_load_ctrl_if.sv
// rtl/shift_load_ctrl_if.sv - request handshake bundle for shift_load_ctrl
interface shift_load_ctrl_if #(
    parameter int MSB = 8
);
    localparam int RW = $clog2(MSB);

    logic [MSB-1:0] in_data;
    logic           in_dir;
    logic [RW-1:0]  in_rot;
    logic           in_valid;
    logic           in_ready;

    modport master (
        output in_data,
        output in_dir,
        output in_rot,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_dir,
        input  in_rot,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/shift_load_ctrl.sv
// rtl/shift_load_ctrl.sv - serial loader, rotator and read-back checker for bidir_shift_reg
module shift_load_ctrl #(
    parameter int MSB = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_load_ctrl_if.slave     req,
    output logic                 sr_d,
    output logic                 sr_en,
    output logic                 sr_dir,
    output logic                 sr_circular,
    output logic                 sr_carry_in,
    input  logic [MSB-1:0]       sr_out,
    output logic                 done,
    output logic                 match
);
    localparam int RW = $clog2(MSB);
    localparam int CW = RW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROT   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state;
    logic           ready_r;
    logic [CW-1:0]  counter;
    logic [MSB-1:0] shadow;
    logic [MSB-1:0] load_word;
    logic           dir;
    logic [RW-1:0]  rot;

    // The register never takes a carry from this loader.
    assign sr_carry_in  = 1'b0;
    assign req.in_ready = ready_r;

    // Sequencer: outputs are registered alongside the state so each one is valid for the
    // whole cycle of the state it belongs to. load_word holds the bits still to be sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ready_r     <= 1'b1;
            sr_d        <= 1'b0;
            sr_en       <= 1'b0;
            sr_dir      <= 1'b0;
            sr_circular <= 1'b0;
            done        <= 1'b0;
            match       <= 1'b0;
            counter     <= '0;
            shadow      <= '0;
            load_word   <= '0;
            dir         <= 1'b0;
            rot         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (req.in_valid) begin
                        state       <= LOAD;
                        ready_r     <= 1'b0;
                        counter     <= '0;
                        shadow      <= req.in_data;
                        dir         <= req.in_dir;
                        rot         <= req.in_rot;
                        sr_en       <= 1'b1;
                        sr_circular <= 1'b0;
                        sr_dir      <= req.in_dir;
                        if (req.in_dir) begin
                            sr_d      <= req.in_data[MSB-1];
                            load_word <= {req.in_data[MSB-2:0], 1'b0};
                        end else begin
                            sr_d      <= req.in_data[0];
                            load_word <= {1'b0, req.in_data[MSB-1:1]};
                        end
                    end
                end
                LOAD: begin
                    if (counter == CW'(MSB - 1)) begin
                        counter <= CW'(1);
                        sr_d    <= 1'b0;
                        if (rot != '0) begin
                            state       <= ROT;
                            sr_circular <= 1'b1;
                        end else begin
                            state <= CHECK;
                            sr_en <= 1'b0;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                        if (dir) begin
                            sr_d      <= load_word[MSB-1];
                            load_word <= {load_word[MSB-2:0], 1'b0};
                        end else begin
                            sr_d      <= load_word[0];
                            load_word <= {1'b0, load_word[MSB-1:1]};
                        end
                    end
                end
                ROT: begin
                    // The shadow follows the register's circular step taken at this edge.
                    if (dir) begin
                        shadow <= {shadow[0], shadow[MSB-1:1]};
                    end else begin
                        shadow <= {shadow[MSB-2:0], shadow[MSB-1]};
                    end
                    if (counter == {1'b0, rot}) begin
                        state       <= CHECK;
                        sr_en       <= 1'b0;
                        sr_circular <= 1'b0;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                CHECK: begin
                    match <= (sr_out == shadow);
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_load_ctrl.sv
// tb/tb_shift_load_ctrl.sv - randomized self-checking bench for shift_load_ctrl
module tb_shift_load_ctrl;
    localparam int MSB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sr_d, sr_en, sr_dir, sr_circular, sr_carry_in;
    logic [7:0] sr_out;
    logic       done, match;
    logic [7:0] sreg = 8'h00;
    logic       sreg_clr = 1'b0;
    logic       force_zero = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    shift_load_ctrl_if #(.MSB(MSB)) bus ();

    shift_load_ctrl #(.MSB(MSB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (bus),
        .sr_d        (sr_d),
        .sr_en       (sr_en),
        .sr_dir      (sr_dir),
        .sr_circular (sr_circular),
        .sr_carry_in (sr_carry_in),
        .sr_out      (sr_out),
        .done        (done),
        .match       (match)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for bidir_shift_reg; force_zero models a broken read-back path.
    always @(posedge clk) begin
        if (sreg_clr)
            sreg <= 8'h00;
        else if (sr_en) begin
            if (!sr_circular)
                sreg <= sr_dir ? {sreg[6:0], sr_d} : {sr_d, sreg[7:1]};
            else
                sreg <= sr_dir ? {sreg[0], sreg[7:1]} : {sreg[6:0], sreg[7]};
        end
    end
    assign sr_out = force_zero ? 8'h00 : sreg;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Rotating a word r times: dir=0 moves bits toward the MSB end, dir=1 toward the LSB end.
    function automatic logic [7:0] rotated(input logic [7:0] w, input bit d, input int r);
        int v = int'(w);
        int res;
        if (d) res = (v >> r) | (v << (8 - r));
        else   res = (v << r) | (v >> (8 - r));
        return 8'(res & 255);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.in_ready), 1);
        check_eq({tag, "_d"},     32'(sr_d), 0);
        check_eq({tag, "_en"},    32'(sr_en), 0);
        check_eq({tag, "_dir"},   32'(sr_dir), 0);
        check_eq({tag, "_circ"},  32'(sr_circular), 0);
        check_eq({tag, "_done"},  32'(done), 0);
        check_eq({tag, "_match"}, 32'(match), 0);
        check_eq({tag, "_carry"}, 32'(sr_carry_in), 0);
    endtask

    // One full operation from IDLE with cycle-exact checks of every phase.
    task automatic run_op(input logic [7:0] w, input bit d, input int r, input bit bad);
        logic [7:0] expv;
        expv = rotated(w, d, r);
        @(negedge clk);
        force_zero = bad;
        check_eq("idle_ready", 32'(bus.in_ready), 1);
        check_eq("idle_en", 32'(sr_en), 0);
        bus.in_data  = w;
        bus.in_dir   = d;
        bus.in_rot   = 3'(r);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int k = 0; k < MSB; k++) begin
            @(negedge clk);
            check_eq("load_en", 32'(sr_en), 1);
            check_eq("load_circ", 32'(sr_circular), 0);
            check_eq("load_dir", 32'(sr_dir), 32'(d));
            check_eq("load_d", 32'(sr_d), 32'(d ? w[7 - k] : w[k]));
            check_eq("load_ready", 32'(bus.in_ready), 0);
            check_eq("load_carry", 32'(sr_carry_in), 0);
        end
        for (int k = 0; k < r; k++) begin
            @(negedge clk);
            check_eq("rot_en", 32'(sr_en), 1);
            check_eq("rot_circ", 32'(sr_circular), 1);
            check_eq("rot_done", 32'(done), 0);
        end
        @(negedge clk);
        check_eq("check_en", 32'(sr_en), 0);
        check_eq("check_done", 32'(done), 0);
        check_eq("check_carry", 32'(sr_carry_in), 0);
        check_eq("reg_contents", 32'(sreg), 32'(expv));
        @(negedge clk);
        check_eq("done_pulse", 32'(done), 1);
        check_eq("done_match", 32'(match), bad ? 32'(expv == 8'h00) : 1);
        check_eq("done_en", 32'(sr_en), 0);
        check_eq("done_ready", 32'(bus.in_ready), 0);
        check_eq("done_carry", 32'(sr_carry_in), 0);
        @(negedge clk);
        check_eq("after_done", 32'(done), 0);
        check_eq("after_ready", 32'(bus.in_ready), 1);
        check_eq("match_hold", 32'(match), bad ? 32'(expv == 8'h00) : 1);
        force_zero = 1'b0;
    endtask

    initial begin
        int d1, d2, rdy, early, pulses;
        bus.in_data = 8'h00; bus.in_dir = 1'b0; bus.in_rot = 3'd0; bus.in_valid = 1'b0;
        sreg_clr = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        sreg_clr = 1'b0;

        run_op(8'hA5, 1'b1, 0, 1'b0);
        run_op(8'h81, 1'b0, 3, 1'b0);
        check_eq("rot3_value", 32'(sr_out), 32'h0C);
        run_op(8'h3C, 1'b1, 0, 1'b1);
        run_op(8'h3C, 1'b1, 0, 1'b0);

        // Asynchronous reset during LOAD cycle 4: no done may follow.
        @(negedge clk);
        bus.in_data = 8'h5A; bus.in_dir = 1'b1; bus.in_rot = 3'd2; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        sreg_clr = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        sreg_clr = 1'b0;
        @(negedge clk);
        check_eq("rst_ready_first", 32'(bus.in_ready), 1);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_eq("rst_no_done", 32'(pulses), 0);

        // Back-to-back with in_valid held high.
        @(negedge clk);
        bus.in_data = 8'hC3; bus.in_dir = 1'b1; bus.in_rot = 3'd1; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_data = 8'h96;
        d1 = -1; d2 = -1; rdy = -1; early = 0; pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rdy >= 0 && k == rdy + 1) bus.in_valid = 1'b0;
            if (done) begin
                pulses++;
                check_eq("b2b_match", 32'(match), 1);
                if (d1 < 0) begin
                    d1 = k;
                    check_eq("b2b_out1", 32'(sr_out), 32'(rotated(8'hC3, 1'b1, 1)));
                end else begin
                    d2 = k;
                    check_eq("b2b_out2", 32'(sr_out), 32'(rotated(8'h96, 1'b1, 1)));
                end
            end
            if (bus.in_ready && d1 < 0) early++;
            if (bus.in_ready && d1 >= 0 && rdy < 0) rdy = k;
        end
        check_eq("b2b_done1_cycle", 32'(d1), 11);
        check_eq("b2b_accept2_cycle", 32'(rdy), 32'(d1 + 1));
        check_eq("b2b_done2_cycle", 32'(d2), 32'(rdy + 11));
        check_eq("b2b_busy_ready", 32'(early), 0);
        check_eq("b2b_pulses", 32'(pulses), 2);

        for (int i = 0; i < 24; i++) begin
            run_op(8'($urandom), 1'($urandom), int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
